// File: rtl/instr_player.sv
// Read side of the instruction queue: pops 5-bit instructions one at a time,
// runs each for STEP_CYCLES with torque PWM and direction, then a dead gap.
module instr_player #(
  parameter int STEP_CYCLES = 50_000_000,
  parameter int DEAD_CYCLES = 500_000,
  parameter int PWM_STEP    = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       fifo_empty,
  input  logic [4:0] fifo_data,
  output logic       fifo_re,
  output logic       busy,
  output logic       done,
  output logic [4:0] cur_instr,
  output logic [7:0] step_count,
  output logic       left_pwm,
  output logic       left_rev,
  output logic       right_pwm,
  output logic       right_rev
);

  localparam int TIMER_MAX  = (STEP_CYCLES > DEAD_CYCLES) ? STEP_CYCLES : DEAD_CYCLES;
  localparam int TIMER_W    = $clog2(TIMER_MAX);
  localparam int PWM_PERIOD = 7 * PWM_STEP;
  localparam int PWM_W      = $clog2(PWM_PERIOD + 1);

  localparam logic [TIMER_W-1:0] STEP_LAST  = TIMER_W'(STEP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DEAD_LAST  = TIMER_W'(DEAD_CYCLES - 1);
  localparam logic [PWM_W-1:0]   PWM_LAST   = PWM_W'(PWM_PERIOD - 1);
  localparam logic [PWM_W-1:0]   PWM_STEP_W = PWM_W'(PWM_STEP);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    RUN,
    GAP,
    FINISH
  } state_t;

  state_t state, next_state;

  logic [TIMER_W-1:0] timer;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [PWM_W-1:0]   duty;
  logic [4:0]         instr;
  logic               pwm_q;

  logic       motors_on;
  logic       busy_d;
  logic       done_d;
  logic       pwm_d;
  logic       left_rev_d;
  logic       right_rev_d;
  logic [4:0] cur_instr_d;

  // Torque 7 gives duty == period, so the output stays constantly high.
  assign duty = PWM_W'(instr[4:2]) * PWM_STEP_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = FETCH;
        FETCH:   next_state = fifo_empty ? FINISH : LOAD;
        LOAD:    next_state = RUN;
        RUN:     if (timer == STEP_LAST) next_state = GAP;
        GAP:     if (timer == DEAD_LAST) next_state = FETCH;
        FINISH:  next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Next-cycle values of the registered outputs; abort kills the motors on the same edge.
  always_comb begin
    fifo_re     = (state == FETCH) && !fifo_empty;
    motors_on   = (state == RUN) && !abort;
    busy_d      = (state != IDLE) && (next_state != IDLE);
    done_d      = (state == FINISH) && !abort;
    pwm_d       = motors_on && (pwm_cnt < duty);
    left_rev_d  = motors_on && (instr[1] ^ instr[0]);
    right_rev_d = motors_on && instr[0];
    cur_instr_d = motors_on ? instr : 5'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      pwm_cnt <= '0;
      instr   <= '0;
    end else begin
      if ((next_state != state) || ((state != RUN) && (state != GAP))) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      if (state == RUN) begin
        pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      end else begin
        pwm_cnt <= '0;
      end

      if (state == LOAD) begin
        instr <= fifo_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_count <= '0;
    end else if ((state == IDLE) && start && !abort) begin
      step_count <= '0;
    end else if ((state == RUN) && (next_state == GAP) && (step_count != 8'hFF)) begin
      step_count <= step_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_instr <= '0;
      pwm_q     <= 1'b0;
      left_rev  <= 1'b0;
      right_rev <= 1'b0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      cur_instr <= cur_instr_d;
      pwm_q     <= pwm_d;
      left_rev  <= left_rev_d;
      right_rev <= right_rev_d;
    end
  end

  assign left_pwm  = pwm_q;
  assign right_pwm = pwm_q;

endmodule

// File: tb/tb_instr_player.sv
// Bench for instr_player: FIFO model plus a scoreboard of queued instructions
// checked cycle by cycle over each expected RUN window.
module tb_instr_player;

  localparam int STEP   = 20;
  localparam int DEAD   = 3;
  localparam int PSTEP  = 2;
  localparam int PERIOD = 7 * PSTEP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [4:0] fifo_data = 5'd0;
  logic       fifo_re;
  logic       busy;
  logic       done;
  logic [4:0] cur_instr;
  logic [7:0] step_count;
  logic       left_pwm;
  logic       left_rev;
  logic       right_pwm;
  logic       right_rev;

  instr_player #(
    .STEP_CYCLES(STEP),
    .DEAD_CYCLES(DEAD),
    .PWM_STEP   (PSTEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_re   (fifo_re),
    .busy      (busy),
    .done      (done),
    .cur_instr (cur_instr),
    .step_count(step_count),
    .left_pwm  (left_pwm),
    .left_rev  (left_rev),
    .right_pwm (right_pwm),
    .right_rev (right_rev)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] instr;
    logic       lrev;
    logic       rrev;
    int         highs;
  } vec_t;

  vec_t       vecs[9];
  logic [4:0] fifo_q[$];
  vec_t       exp_q[$];
  vec_t       cur_exp;

  int n_vec = 0;
  int n_err = 0;
  int cyc, n_re, n_done, done_cyc, first_re, busy_cnt;
  int pend = 0;
  int win_k = 0;
  int high_cnt = 0;
  bit in_win = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_entry(input vec_t v);
    fifo_q.push_back(v.instr);
    exp_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic reset_counters();
    cyc      = -1;
    n_re     = 0;
    n_done   = 0;
    done_cyc = -1;
    first_re = -1;
    busy_cnt = 0;
  endtask

  // One clock: FIFO model pops on fifo_re, then outputs are compared to the window model.
  task automatic tick();
    logic re, ab, exp_pwm;
    re = fifo_re;
    ab = abort;
    @(posedge clk);
    #1;
    cyc++;
    if (re) begin
      if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      n_re++;
      if (first_re < 0) first_re = cyc;
    end
    fifo_empty = (fifo_q.size() == 0);
    if (ab) begin
      in_win = 1'b0;
      pend   = 0;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        in_win   = 1'b1;
        win_k    = 0;
        high_cnt = 0;
      end
    end
    if (in_win) begin
      exp_pwm = (win_k % PERIOD) < (int'(cur_exp.instr[4:2]) * PSTEP);
      checkOutput("cur_instr", cur_instr, cur_exp.instr);
      checkOutput("left_rev", left_rev, cur_exp.lrev);
      checkOutput("right_rev", right_rev, cur_exp.rrev);
      checkOutput("left_pwm", left_pwm, exp_pwm);
      checkOutput("right_pwm", right_pwm, exp_pwm);
      if (left_pwm === 1'b1) high_cnt++;
      win_k++;
      if (win_k == STEP) begin
        in_win = 1'b0;
        checkOutput("pwm_high_cycles", high_cnt, cur_exp.highs);
      end
    end else begin
      checkOutput("motors_off", {cur_instr, left_pwm, left_rev, right_pwm, right_rev}, 0);
    end
    if (re) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_pop: got fifo_re=1, expected 0");
      end else begin
        cur_exp = exp_q.pop_front();
        if (!ab) pend = 2;
      end
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) tick();
    if (n_done == 0) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL done_timeout: got no done in %0d cycles, expected a pulse", budget);
    end
    repeat (2) tick();
  endtask

  task automatic wait_run_cycle(input int k, input int budget);
    for (int i = 0; i < budget && !(in_win && win_k == k); i++) tick();
    checkOutput("reach_run_cycle", (in_win && win_k == k), 1);
  endtask

  initial begin
    vecs[0] = '{5'b011_00, 1'b0, 1'b0, 12};
    vecs[1] = '{5'b111_11, 1'b0, 1'b1, 20};
    vecs[2] = '{5'b000_01, 1'b1, 1'b1, 0};
    vecs[3] = '{5'b101_10, 1'b1, 1'b0, 16};
    vecs[4] = '{5'b001_11, 1'b0, 1'b1, 4};
    vecs[5] = '{5'b010_01, 1'b1, 1'b1, 8};
    vecs[6] = '{5'b110_00, 1'b0, 1'b0, 18};
    vecs[7] = '{5'b100_10, 1'b1, 1'b0, 14};
    vecs[8] = '{5'b011_11, 1'b0, 1'b1, 12};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {fifo_re, busy, done, cur_instr, step_count, left_pwm, left_rev, right_pwm, right_rev}, 0);
    rst_n = 1'b1;
    reset_counters();
    repeat (2) tick();

    // Two-instruction queue from the worked example.
    reset_counters();
    push_entry(vecs[0]);
    push_entry(vecs[1]);
    applyStimulus(1'b1, 1'b0);
    run_to_done(200);
    checkOutput("first_fifo_re_cycle", first_re, 1);
    checkOutput("pop_count", n_re, 2);
    checkOutput("done_count", n_done, 1);
    checkOutput("done_cycle", done_cyc, 52);
    checkOutput("busy_cycles", busy_cnt, 51);
    checkOutput("step_count", step_count, 2);

    // Empty FIFO.
    reset_counters();
    applyStimulus(1'b1, 1'b0);
    run_to_done(20);
    checkOutput("empty_pop_count", n_re, 0);
    checkOutput("empty_done_cycle", done_cyc, 2);
    checkOutput("empty_busy_cycles", busy_cnt, 1);
    checkOutput("empty_step_count", step_count, 0);

    // Remaining table entries in one playback.
    reset_counters();
    for (int i = 2; i < 9; i++) push_entry(vecs[i]);
    applyStimulus(1'b1, 1'b0);
    run_to_done(400);
    checkOutput("table_pop_count", n_re, 7);
    checkOutput("table_done_cycle", done_cyc, 2 + 25 * 7);
    checkOutput("table_step_count", step_count, 7);

    // start and abort together in IDLE: abort wins.
    push_entry(vecs[2]);
    reset_counters();
    applyStimulus(1'b1, 1'b1);
    repeat (5) tick();
    checkOutput("startabort_pops", n_re, 0);
    checkOutput("startabort_busy", busy_cnt, 0);
    checkOutput("startabort_fifo_left", fifo_q.size(), 1);
    checkOutput("startabort_step_count", step_count, 7);
    reset_counters();
    applyStimulus(1'b1, 1'b0);
    run_to_done(60);
    checkOutput("single_pop_count", n_re, 1);
    checkOutput("single_done_cycle", done_cyc, 27);
    checkOutput("single_step_count", step_count, 1);

    // Abort at RUN cycle 10 of a three-entry queue, then resume.
    reset_counters();
    push_entry(vecs[3]);
    push_entry(vecs[4]);
    push_entry(vecs[5]);
    applyStimulus(1'b1, 1'b0);
    wait_run_cycle(10, 50);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_busy", busy, 0);
    repeat (4) tick();
    checkOutput("abort_done_count", n_done, 0);
    checkOutput("abort_pop_count", n_re, 1);
    checkOutput("abort_fifo_left", fifo_q.size(), 2);
    checkOutput("abort_step_count", step_count, 0);
    reset_counters();
    applyStimulus(1'b1, 1'b0);
    wait_run_cycle(5, 50);
    applyStimulus(1'b1, 1'b0);
    run_to_done(200);
    checkOutput("resume_pop_count", n_re, 2);
    checkOutput("resume_done_count", n_done, 1);
    checkOutput("resume_done_cycle", done_cyc, 52);
    checkOutput("resume_step_count", step_count, 2);

    // Asynchronous reset in the middle of RUN.
    reset_counters();
    push_entry(vecs[6]);
    applyStimulus(1'b1, 1'b0);
    wait_run_cycle(7, 50);
    checkOutput("pre_reset_cur_instr", cur_instr, vecs[6].instr);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {fifo_re, busy, done, cur_instr, step_count, left_pwm, left_rev, right_pwm, right_rev}, 0);
    #2 rst_n = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    in_win     = 1'b0;
    pend       = 0;
    fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    reset_counters();
    repeat (3) tick();
    checkOutput("post_reset_busy", busy_cnt, 0);
    checkOutput("post_reset_step_count", step_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
